// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the program/data memory arbiter.
package mem_arbiter_pkg;

  // Loader-side access sequence: capture the request, wait for a free slot, acknowledge.
  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_WAIT = 2'd1,
    L_ACK  = 2'd2
  } arb_state_t;

  // Bits needed to hold a counter that runs from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; tracks loader wait cycles.
module sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign count  = count_q;
  assign at_max = (count_q == MAX_V);

  // Next count: clear has priority, otherwise step until MAX and hold there.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_) begin
    // NOTE: clocked state uses non-blocking assignments so all flops update together.
    if (!rst_) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: the CPU always owns the port when it strobes; the
// loader/debug port borrows idle cycles, and owns the memory once the CPU halts.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic          cpu_halt,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          lr_req,
  input  logic          lr_we,
  input  logic [AW-1:0] lr_addr,
  input  logic [DW-1:0] lr_wdata,
  output logic          lr_ack,
  output logic [DW-1:0] lr_rdata,
  output logic          lr_starve,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = cnt_width(MAX_WAIT);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  arb_state_t    state_q, state_d;
  logic          halted_q, halted_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] lr_rdata_q, lr_rdata_d;

  logic          slot_free;
  logic          grant_lr;
  logic          capture;
  logic          wait_inc;
  logic [CW-1:0] wait_cnt;
  logic          wait_at_max;

  // Loader wait-cycle counter; cleared when a new request is captured.
  sat_counter #(
    .W   (CW),
    .MAX (MAX_WAIT)
  ) u_wait_cnt (
    .clk    (clk),
    .rst_   (rst_),
    .clear  (capture),
    .inc    (wait_inc),
    .count  (wait_cnt),
    .at_max (wait_at_max)
  );

  assign cpu_rdata = mem_rdata;
  assign lr_rdata  = lr_rdata_q;
  assign lr_ack    = (state_q == L_ACK);
  assign lr_starve = (wait_cnt == MAX_CNT);

  // Slot detection, loader FSM next state, request capture and memory port mux.
  always_comb begin
    slot_free  = halted_q | (!cpu_rd & !cpu_wr);
    grant_lr   = (state_q == L_WAIT) && slot_free;
    capture    = (state_q == L_IDLE) && lr_req;
    wait_inc   = (state_q == L_WAIT) && !slot_free && !wait_at_max;

    state_d    = state_q;
    halted_d   = halted_q | cpu_halt;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lr_rdata_d = lr_rdata_q;

    // CPU owns the port unless the loader is granted; strobes are blocked after halt.
    mem_rd     = cpu_rd & !cpu_wr & !halted_q;
    mem_wr     = cpu_wr & !halted_q;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;

    unique case (state_q)
      L_IDLE: begin
        if (lr_req) begin
          we_d    = lr_we;
          addr_d  = lr_addr;
          wdata_d = lr_wdata;
          state_d = L_WAIT;
        end
      end
      L_WAIT: begin
        if (grant_lr) begin
          mem_rd    = !we_q;
          mem_wr    = we_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          if (!we_q) begin
            lr_rdata_d = mem_rdata;
          end
          state_d = L_ACK;
        end
      end
      L_ACK: begin
        state_d = L_IDLE;
      end
      default: begin
        state_d = L_IDLE;
      end
    endcase
  end

  // FSM state, captured request, halt latch and loader read data.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= L_IDLE;
      halted_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lr_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lr_rdata_q <= lr_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory.
module tb_mem_arbiter;

  localparam int AW       = 5;
  localparam int DW       = 8;
  localparam int MAX_WAIT = 3;

  logic          clk;
  logic          rst_;
  logic          cpu_rd, cpu_wr, cpu_halt;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          lr_req, lr_we;
  logic [AW-1:0] lr_addr;
  logic [DW-1:0] lr_wdata;
  logic          lr_ack;
  logic [DW-1:0] lr_rdata;
  logic          lr_starve;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [32];

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_halt  (cpu_halt),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .lr_req    (lr_req),
    .lr_we     (lr_we),
    .lr_addr   (lr_addr),
    .lr_wdata  (lr_wdata),
    .lr_ack    (lr_ack),
    .lr_rdata  (lr_rdata),
    .lr_starve (lr_starve),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem_rd ? mem[mem_addr] : '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe exclusivity check, used every cycle in the traffic-heavy sections.
  task automatic check_excl(input string tag);
    check(tag, {31'd0, mem_rd & mem_wr}, 32'd0);
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ = 1'b0;
    cpu_rd = 0; cpu_wr = 0; cpu_halt = 0; cpu_addr = '0; cpu_wdata = '0;
    lr_req = 0; lr_we = 0; lr_addr = '0; lr_wdata = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // Reset state.
    #2;
    check("rst_ack",    {31'd0, lr_ack},    32'd0);
    check("rst_starve", {31'd0, lr_starve}, 32'd0);
    check("rst_rdata",  {24'd0, lr_rdata},  32'd0);
    check("rst_mem_wr", {31'd0, mem_wr},    32'd0);
    check("rst_mem_rd", {31'd0, mem_rd},    32'd0);
    cyc();
    cyc();
    rst_ = 1'b1;

    // 1: loader write with the CPU idle.
    cyc();
    lr_req = 1; lr_we = 1; lr_addr = 5'h1A; lr_wdata = 8'h3C;
    #2;
    check("t1_capture_wr", {31'd0, mem_wr}, 32'd0);
    check("t1_capture_rd", {31'd0, mem_rd}, 32'd0);
    cyc(); #2;
    check("t1_grant_wr",    {31'd0, mem_wr},   32'd1);
    check("t1_grant_addr",  {27'd0, mem_addr}, 32'h1A);
    check("t1_grant_wdata", {24'd0, mem_wdata}, 32'h3C);
    check("t1_grant_noack", {31'd0, lr_ack},   32'd0);
    cyc();
    lr_req = 0;
    #2;
    check("t1_ack",      {31'd0, lr_ack}, 32'd1);
    check("t1_ack_nowr", {31'd0, mem_wr}, 32'd0);
    cyc(); #2;
    check("t1_ack_drop", {31'd0, lr_ack}, 32'd0);
    check("t1_mem",      {24'd0, mem[5'h1A]}, 32'h3C);

    // 2: loader read while the CPU reads for 4 cycles.
    cyc();
    lr_req = 1; lr_we = 0; lr_addr = 5'h1A; cpu_rd = 1; cpu_addr = 5'h05;
    #2;
    check("t2_cap_addr", {27'd0, mem_addr}, 32'h05);
    check("t2_cap_rd",   {31'd0, mem_rd},   32'd1);
    for (int k = 1; k <= 4; k++) begin
      cyc(); #2;
      check("t2_wait_addr",   {27'd0, mem_addr}, 32'h05);
      check("t2_wait_noack",  {31'd0, lr_ack},   32'd0);
      check("t2_wait_starve", {31'd0, lr_starve}, (k >= 4) ? 32'd1 : 32'd0);
    end
    cyc();
    cpu_rd = 0;
    #2;
    check("t2_grant_rd",     {31'd0, mem_rd},   32'd1);
    check("t2_grant_wr",     {31'd0, mem_wr},   32'd0);
    check("t2_grant_addr",   {27'd0, mem_addr}, 32'h1A);
    check("t2_grant_starve", {31'd0, lr_starve}, 32'd1);
    cyc();
    lr_req = 0;
    #2;
    check("t2_ack",   {31'd0, lr_ack},   32'd1);
    check("t2_rdata", {24'd0, lr_rdata}, 32'h3C);

    // 3: starvation with MAX_WAIT=3 while the CPU reads for 6 cycles.
    cyc();
    lr_req = 1; lr_we = 1; lr_addr = 5'h02; lr_wdata = 8'hA5; cpu_rd = 1; cpu_addr = 5'h11;
    #2;
    for (int k = 1; k <= 6; k++) begin
      cyc(); #2;
      check("t3_cpu_addr", {27'd0, mem_addr}, 32'h11);
      check("t3_cpu_rd",   {31'd0, mem_rd},   32'd1);
      check("t3_no_wr",    {31'd0, mem_wr},   32'd0);
      check("t3_starve",   {31'd0, lr_starve}, (k >= 4) ? 32'd1 : 32'd0);
    end
    cyc();
    cpu_rd = 0;
    #2;
    check("t3_grant_wr",   {31'd0, mem_wr},    32'd1);
    check("t3_grant_addr", {27'd0, mem_addr},  32'h02);
    check("t3_grant_data", {24'd0, mem_wdata}, 32'hA5);
    cyc();
    lr_req = 0;
    #2;
    check("t3_ack", {31'd0, lr_ack}, 32'd1);
    cyc(); #2;
    check("t3_mem", {24'd0, mem[5'h02]}, 32'hA5);

    // 5: reset while a loader write is waiting.
    cyc();
    lr_req = 1; lr_we = 1; lr_addr = 5'h0F; lr_wdata = 8'h99; cpu_rd = 1; cpu_addr = 5'h04;
    #2;
    for (int k = 1; k <= 4; k++) begin
      cyc(); #2;
      check("t5_wait_nowr", {31'd0, mem_wr}, 32'd0);
    end
    check("t5_pre_starve", {31'd0, lr_starve}, 32'd1);
    rst_ = 1'b0;
    #1;
    check("t5_async_starve", {31'd0, lr_starve}, 32'd0);
    check("t5_async_ack",    {31'd0, lr_ack},    32'd0);
    check("t5_async_rdata",  {24'd0, lr_rdata},  32'd0);
    cpu_rd = 0;
    #1;
    check("t5_rst_nowr", {31'd0, mem_wr}, 32'd0);
    cyc(); #2;
    check("t5_hold_nowr",  {31'd0, mem_wr}, 32'd0);
    check("t5_hold_noack", {31'd0, lr_ack}, 32'd0);
    cyc();
    rst_ = 1'b1; lr_req = 0;
    #2;
    check("t5_rel_noack", {31'd0, lr_ack}, 32'd0);
    check("t5_rel_nowr",  {31'd0, mem_wr}, 32'd0);
    cyc(); #2;
    check("t5_mem_untouched", {24'd0, mem[5'h0F]}, 32'h00);
    check("t5_idle_noack",    {31'd0, lr_ack},     32'd0);

    // 6: back-to-back requests with lr_req held through ack.
    cyc();
    lr_req = 1; lr_we = 1; lr_addr = 5'h03; lr_wdata = 8'h77;
    #2;
    for (int j = 0; j < 6; j++) begin
      if (j != 0) begin
        cyc(); #2;
      end
      check("t6_ack", {31'd0, lr_ack}, (j == 2 || j == 5) ? 32'd1 : 32'd0);
      check("t6_wr",  {31'd0, mem_wr}, (j == 1 || j == 4) ? 32'd1 : 32'd0);
      check_excl("t6_excl");
    end
    cyc();
    lr_req = 0;
    #2;
    check("t6_done_noack", {31'd0, lr_ack}, 32'd0);
    check("t6_done_nowr",  {31'd0, mem_wr}, 32'd0);
    check("t6_mem",        {24'd0, mem[5'h03]}, 32'h77);

    // 4: halt, then CPU strobes are blocked and the loader is served immediately.
    cyc();
    cpu_halt = 1;
    #2;
    check("t4_halt_rd", {31'd0, mem_rd}, 32'd0);
    cyc();
    cpu_halt = 0; cpu_rd = 1; cpu_addr = 5'h07;
    lr_req = 1; lr_we = 0; lr_addr = 5'h02;
    #2;
    check("t4_blocked_rd", {31'd0, mem_rd}, 32'd0);
    check_excl("t4_excl_cap");
    cyc(); #2;
    check("t4_grant_rd",   {31'd0, mem_rd},   32'd1);
    check("t4_grant_wr",   {31'd0, mem_wr},   32'd0);
    check("t4_grant_addr", {27'd0, mem_addr}, 32'h02);
    cyc();
    lr_req = 0;
    #2;
    check("t4_ack",        {31'd0, lr_ack},   32'd1);
    check("t4_rdata",      {24'd0, lr_rdata}, 32'hA5);
    check("t4_ack_noread", {31'd0, mem_rd},   32'd0);
    cyc();
    cpu_rd = 0; cpu_wr = 1; cpu_addr = 5'h02; cpu_wdata = 8'hFF;
    #2;
    check("t4_blocked_wr", {31'd0, mem_wr}, 32'd0);
    cyc();
    cpu_wr = 0;
    #2;
    check("t4_mem_kept", {24'd0, mem[5'h02]}, 32'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
